// File: rtl/conv_pkg.sv
// Shared types, default polynomials and helpers for the convolutional encoder
// and the decoder-side reference models that reuse its step function.
package conv_pkg;

  typedef enum logic {DATA, TAIL} conv_state_e;

  localparam int PARITY_W = 64;

  // LTE turbo constituent code (13/15 octal) and the classic K=3 code (7/5 octal)
  localparam logic [3:0] G_LTE_FB    = 4'b1011;
  localparam logic [3:0] G_LTE_FF    = 4'b1101;
  localparam logic [2:0] G_CLASSIC_7 = 3'b111;
  localparam logic [2:0] G_CLASSIC_5 = 3'b101;

  function automatic logic parity(input logic [PARITY_W-1:0] vec);
    return ^vec;
  endfunction

endpackage

// File: rtl/conv_encoder_term_if.sv
// Streaming bus of the encoder: information bits in, coded symbols out.
interface conv_encoder_term_if #(
  parameter int N_OUT = 2
);

  logic             s_valid;
  logic             s_ready;
  logic             s_data;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [N_OUT-1:0] m_data;
  logic             m_tail;
  logic             m_last;

  // master is the encoder's view; slave is the environment feeding and draining it
  modport master (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_tail, m_last
  );

  modport slave (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_tail, m_last
  );

endinterface

// File: rtl/conv_encoder_core.sv
// Purely combinational trellis step: (d, S) -> (f, coded symbol, S').
module conv_encoder_core
  import conv_pkg::*;
#(
  parameter int                 K         = 4,
  parameter int                 N_OUT     = 2,
  parameter int                 RECURSIVE = 1,
  parameter logic [K-1:0]       G_FB      = 4'b1011,
  parameter logic [N_OUT*K-1:0] G_FF      = {4'b1101, 4'b1011}
) (
  input  logic             d,
  input  logic [K-2:0]     state,
  output logic             f,
  output logic [N_OUT-1:0] code,
  output logic [K-2:0]     next_state
);

  logic fb_par;

  assign fb_par = parity(PARITY_W'(state & G_FB[K-2:0]));
  assign f      = (RECURSIVE != 0) ? (d ^ fb_par) : d;

  for (genvar j = 0; j < N_OUT; j++) begin : g_poly
    assign code[j] = parity(PARITY_W'({f, state} & G_FF[j*K +: K]));
  end

  // With K=2 the state is a single bit, so the shift degenerates to f alone
  if (K > 2) begin : g_shift
    assign next_state = {f, state[K-2:1]};
  end else begin : g_shift_k2
    assign next_state = f;
  end

endmodule

// File: rtl/conv_encoder_term.sv
// Rate-1/N_OUT convolutional encoder with registered output stage and
// optional K-1 symbol trellis termination after every frame.
module conv_encoder_term
  import conv_pkg::*;
#(
  parameter int                 K         = 4,
  parameter int                 N_OUT     = 2,
  parameter int                 RECURSIVE = 1,
  parameter logic [K-1:0]       G_FB      = G_LTE_FB,
  parameter logic [N_OUT*K-1:0] G_FF      = {G_LTE_FF, G_LTE_FB},
  parameter int                 TERMINATE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  conv_encoder_term_if.master bus,
  output logic [K-2:0]        state_o
);

  localparam int CW = (K > 2) ? $clog2(K - 1) : 1;

  conv_state_e      fsm_q, fsm_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [K-2:0]     state_q, state_d, core_next;
  logic [N_OUT-1:0] core_code, m_data_q;
  logic             m_valid_q, m_tail_q, m_last_q;
  logic             load_ok, accept, tail_step, load, sym_tail, sym_last;
  logic             tail_in, core_d, core_f;

  assign load_ok     = !m_valid_q || bus.m_ready;
  assign bus.s_ready = (fsm_q == DATA) && load_ok && !clear;
  assign accept      = bus.s_valid && bus.s_ready;
  assign tail_step   = (fsm_q == TAIL) && load_ok && !clear;

  // Tail input cancels the feedback so f=0 and zeros shift in behind it
  assign tail_in = (RECURSIVE != 0) ? parity(PARITY_W'(state_q & G_FB[K-2:0])) : 1'b0;
  assign core_d  = (fsm_q == TAIL) ? tail_in : bus.s_data;

  conv_encoder_core #(
    .K(K), .N_OUT(N_OUT), .RECURSIVE(RECURSIVE), .G_FB(G_FB), .G_FF(G_FF)
  ) u_core (
    .d(core_d), .state(state_q), .f(core_f), .code(core_code), .next_state(core_next)
  );

  always_comb begin
    if (fsm_q == TAIL) assert (core_f == 1'b0);
  end

  always_comb begin
    fsm_d    = fsm_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    load     = 1'b0;
    sym_tail = 1'b0;
    sym_last = 1'b0;
    if (clear) begin
      fsm_d   = DATA;
      cnt_d   = '0;
      state_d = '0;
    end else if (accept) begin
      load    = 1'b1;
      state_d = core_next;
      if (bus.s_last) begin
        if (TERMINATE != 0) begin
          fsm_d = TAIL;
          cnt_d = '0;
        end else begin
          sym_last = 1'b1;
          state_d  = '0;
        end
      end
    end else if (tail_step) begin
      load     = 1'b1;
      sym_tail = 1'b1;
      state_d  = core_next;
      if (cnt_q == CW'(K - 2)) begin
        sym_last = 1'b1;
        fsm_d    = DATA;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q   <= DATA;
      cnt_q   <= '0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Output stage holds until accepted; a fresh symbol may load in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_tail_q  <= 1'b0;
      m_last_q  <= 1'b0;
    end else if (clear) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_tail_q  <= 1'b0;
      m_last_q  <= 1'b0;
    end else if (load) begin
      m_valid_q <= 1'b1;
      m_data_q  <= core_code;
      m_tail_q  <= sym_tail;
      m_last_q  <= sym_last;
    end else if (bus.m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_tail  = m_tail_q;
  assign bus.m_last  = m_last_q;
  assign state_o     = state_q;

endmodule
